// File: rtl/queue_counter.sv
// Queue occupancy counter: edge-detects the FSM up/down levels into a saturating count,
// with full/empty flags, error pulses and a registered wait time. Optional QUEUE_WAIT_BCD_EN.
module queue_counter #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_COUNT = 9,
    parameter int unsigned SVC_TIME  = 3,
    parameter int unsigned WAIT_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              down,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err,
    output logic [WAIT_W-1:0] wait_time
`ifdef QUEUE_WAIT_BCD_EN
    ,
    output logic [7:0]        wait_bcd
`endif
);

    if (64'(MAX_COUNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
        $error("queue_counter: MAX_COUNT does not fit in CNT_W bits");
    end
    if (64'(MAX_COUNT) * 64'(SVC_TIME) > ((64'd1 << WAIT_W) - 64'd1)) begin : g_bad_wait_w
        $error("queue_counter: MAX_COUNT*SVC_TIME does not fit in WAIT_W bits");
    end

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

    logic              up_d, down_d;
    logic              up_evt, down_evt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign up_evt   = up & ~up_d;
    assign down_evt = down & ~down_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        // Simultaneous up/down events cancel: no change, no error.
        if (up_evt && !down_evt) begin
            if (count_q == MaxCnt) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (down_evt && !up_evt) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Wait time follows the count register, so it lags count by one cycle.
    assign wait_d = WAIT_W'(count_q) * WAIT_W'(SVC_TIME);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_d    <= 1'b0;
            down_d  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            up_d    <= up;
            down_d  <= down;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            wait_q  <= wait_d;
        end
    end

    assign count     = count_q;
    assign full      = (count_q == MaxCnt);
    assign empty     = (count_q == '0);
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign wait_time = wait_q;

`ifdef QUEUE_WAIT_BCD_EN
    logic [31:0] wait_val;
    logic [7:0]  bcd_d, bcd_q;

    always_comb begin
        wait_val = 32'(wait_d);
        if (wait_val > 32'd99) begin
            bcd_d = 8'h99;
        end else begin
            bcd_d = {4'(wait_val / 32'd10), 4'(wait_val % 32'd10)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign wait_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_queue_counter.sv
// Directed, table-driven bench for queue_counter (MAX_COUNT=9, SVC_TIME=3).
module tb_queue_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [3:0] count;
    logic       full, empty, ovf_err, unf_err;
    logic [6:0] wait_time;
`ifdef QUEUE_WAIT_BCD_EN
    logic [7:0] wait_bcd;
`endif

    int tests = 0;
    int fails = 0;

    queue_counter #(
        .CNT_W    (4),
        .MAX_COUNT(9),
        .SVC_TIME (3),
        .WAIT_W   (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err),
        .wait_time(wait_time)
`ifdef QUEUE_WAIT_BCD_EN
        ,
        .wait_bcd (wait_bcd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    u;
        logic    d;
        int      cnt;
        int      wt;
        logic    ovf;
        logic    unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // full/empty/bcd expectations derive from the hand-written count/wait columns.
    task automatic chk_all(input string tag, input int c, input int w, input logic o,
                           input logic u);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".full"}, int'(full), int'(c == 9));
        chk({tag, ".empty"}, int'(empty), int'(c == 0));
        chk({tag, ".ovf_err"}, int'(ovf_err), int'(o));
        chk({tag, ".unf_err"}, int'(unf_err), int'(u));
        chk({tag, ".wait_time"}, int'(wait_time), w);
`ifdef QUEUE_WAIT_BCD_EN
        chk({tag, ".wait_bcd"}, int'(wait_bcd),
            (w > 99) ? 'h99 : (((w / 10) << 4) | (w % 10)));
`endif
    endtask

    task automatic v(input logic u, input logic d, input int c, input int w,
                     input logic o = 1'b0, input logic n = 1'b0);
        vec_t e;
        e.u = u; e.d = d; e.cnt = c; e.wt = w; e.ovf = o; e.unf = n;
        vecs.push_back(e);
    endtask

    task automatic step(input logic u, input logic d);
        up   = u;
        down = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle after reset
        v(0, 0, 0, 0);
        v(0, 0, 0, 0);
        // Level held 6 cycles gives one increment; wait lags by one cycle
        v(1, 0, 1, 0);
        v(1, 0, 1, 3);
        v(1, 0, 1, 3);
        v(1, 0, 1, 3);
        v(1, 0, 1, 3);
        v(1, 0, 1, 3);
        v(0, 0, 1, 3);
        // Fill to 9
        for (int i = 2; i <= 9; i++) begin
            v(1, 0, i, (i - 1) * 3);
            v(0, 0, i, i * 3);
        end
        // 10th pulse at full, held two cycles: one-cycle overflow pulse
        v(1, 0, 9, 27, 1'b1);
        v(1, 0, 9, 27);
        v(0, 0, 9, 27);
        // Drain to 4
        for (int i = 8; i >= 4; i--) begin
            v(0, 1, i, (i + 1) * 3);
            v(0, 0, i, i * 3);
        end
        // Simultaneous rise: net zero, no error
        v(1, 1, 4, 12);
        v(0, 0, 4, 12);
        // Up 3 cycles then straight to down
        v(1, 0, 5, 12);
        v(1, 0, 5, 15);
        v(1, 0, 5, 15);
        v(0, 1, 4, 15);
        v(0, 1, 4, 12);
        v(0, 0, 4, 12);
        // Drain to 0, then underflow
        for (int i = 3; i >= 0; i--) begin
            v(0, 1, i, (i + 1) * 3);
            v(0, 0, i, i * 3);
        end
        v(0, 1, 0, 0, 1'b0, 1'b1);
        v(0, 1, 0, 0);
        v(0, 0, 0, 0);

        // Reset state
        #2 rst = 1'b1;
        #2 chk_all("reset", 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].u, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wt, vecs[i].ovf,
                    vecs[i].unf);
        end

        // Count to 5, then asynchronous reset mid-cycle clears everything at once
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            step(0, 0);
        end
        step(0, 0);
        chk_all("pre_rst", 5, 15, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_all("mid_rst", 0, 0, 1'b0, 1'b0);
        step(0, 0);
        chk_all("rst_held", 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        step(0, 0);
        chk_all("post_rst_idle0", 0, 0, 1'b0, 1'b0);
        step(0, 0);
        chk_all("post_rst_idle1", 0, 0, 1'b0, 1'b0);

        // up held across reset release counts as a fresh event
        up = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_all("up_thru_rst0", 0, 0, 1'b0, 1'b0);
        step(1, 0);
        chk_all("up_thru_rst1", 1, 0, 1'b0, 1'b0);
        step(1, 0);
        chk_all("up_thru_rst2", 1, 3, 1'b0, 1'b0);
        step(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
